// File: rtl/cv32e40p_hwloop_sequencer.sv
// Hardware-loop sequencer: watches the instruction in ID, issues per-loop
// decrement strobes at loop ends and a registered jump request back to the
// loop start while further iterations remain.
// Optional build macro: CV32E40P_HWLP_PERF_EN (taken-jump counter on
// hwlp_jump_cnt_o; tied to 0 when undefined).

// Per-loop end-address match and activity flag.
module cv32e40p_hwloop_lane (
  input  logic        id_valid,
  input  logic [31:0] pc,
  input  logic [31:0] end_addr,
  input  logic [31:0] cnt,
  input  logic        wr_hit,
  output logic        match,
  output logic        active
);
  assign active = (cnt != 32'd0);
  // A loop being rewritten this cycle must not be acted on with stale values.
  assign match  = id_valid && (pc == end_addr) && active && !wr_hit;
endmodule

module cv32e40p_hwloop_sequencer #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   id_pc_i,
  input  logic                          id_valid_i,
  input  logic                          id_ready_i,
  input  logic                          flush_i,
  input  logic [N_REGS-1:0][31:0]       hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]       hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]       hwlp_counter_i,
  input  logic [2:0]                    hwlp_we_i,
  input  logic [N_REG_BITS-1:0]         hwlp_regid_i,
  input  logic                          jump_ack_i,
  output logic [N_REGS-1:0]             hwlp_dec_cnt_o,
  output logic                          hwlp_jump_o,
  output logic [31:0]                   hwlp_target_o,
  output logic [N_REGS-1:0]             hwlp_active_o,
  output logic [31:0]                   hwlp_jump_cnt_o
);

  typedef enum logic {IDLE = 1'b0, JUMP = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             target_q, target_d;
  logic [N_REGS-1:0]       match;
  logic [N_REG_BITS-1:0]   sel;
  logic                    any_match;
  logic                    retire;
  logic                    more_iter;

  genvar k;
  generate
    for (k = 0; k < N_REGS; k++) begin : g_lane
      cv32e40p_hwloop_lane u_lane (
        .id_valid (id_valid_i),
        .pc       (id_pc_i),
        .end_addr (hwlp_end_addr_i[k]),
        .cnt      (hwlp_counter_i[k]),
        .wr_hit   ((|hwlp_we_i) && (hwlp_regid_i == N_REG_BITS'(k))),
        .match    (match[k]),
        .active   (hwlp_active_o[k])
      );
    end
  endgenerate

  // Priority pick: innermost (lowest index) matching loop wins.
  always_comb begin
    sel       = '0;
    any_match = 1'b0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel       = N_REG_BITS'(i);
        any_match = 1'b1;
      end
    end
  end

  // Retiring only counts in IDLE; in JUMP the ID instruction is wrong-path.
  assign retire    = any_match && id_ready_i && (state_q == IDLE) && !flush_i;
  // Unsigned compare, so 0xFFFFFFFF still loops back.
  assign more_iter = hwlp_counter_i[sel] > 32'd1;

  // State, target and jump request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next state, jump target and decrement strobe.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    hwlp_dec_cnt_o = '0;
    case (state_q)
      IDLE: begin
        if (retire) begin
          hwlp_dec_cnt_o[sel] = 1'b1;
          if (more_iter) begin
            state_d  = JUMP;
            target_d = hwlp_start_addr_i[sel];
          end
        end
      end
      JUMP: begin
        // Flush and ack both end the request; either way back to IDLE.
        if (flush_i || jump_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hwlp_jump_o   = (state_q == JUMP);
  assign hwlp_target_o = target_q;

`ifdef CV32E40P_HWLP_PERF_EN
  logic [31:0] jump_cnt_q;

  // Saturating count of IDLE->JUMP transitions, flushed jumps included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      jump_cnt_q <= '0;
    else if (state_q == IDLE && state_d == JUMP && jump_cnt_q != 32'hFFFF_FFFF)
      jump_cnt_q <= jump_cnt_q + 32'd1;
  end

  assign hwlp_jump_cnt_o = jump_cnt_q;
`else
  assign hwlp_jump_cnt_o = '0;
`endif

endmodule
